// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-ported register file with dual write, bypass and busy scoreboard
module regfile_mp #(
  parameter int N      = 32,
  parameter int SIZE   = 64,
  parameter int NR     = 2,
  parameter int BYPASS = 1,
  localparam int AW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NR*AW-1:0] RA,
  output logic [NR*SIZE-1:0] DA,
  output logic [NR-1:0]    RBUSY,
  input  logic             WE0,
  input  logic [AW-1:0]    RW0,
  input  logic [SIZE-1:0]  DIN0,
  input  logic             WE1,
  input  logic [AW-1:0]    RW1,
  input  logic [SIZE-1:0]  DIN1,
  input  logic             ISSUE,
  input  logic [AW-1:0]    RI
);

  // Register 0 is not stored; index range starts at 1.
  logic [SIZE-1:0] r_mem [1:N-1];
  logic [N-1:1]    r_busy;

  logic [AW-1:0]   w_sel;
  logic [SIZE-1:0] w_stored;
  logic            w_busy;
  logic            w_hit;
  logic            w_fwd0;
  logic            w_fwd1;

  // Storage and scoreboard update; port 1 wins a same-register write, issue wins over retire.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 1; i < N; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 1; i < N; i++) begin
        if (WE1 && (RW1 == AW'(i))) begin
          r_mem[i] <= DIN1;
        end else if (WE0 && (RW0 == AW'(i))) begin
          r_mem[i] <= DIN0;
        end
        if (ISSUE && (RI == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((WE0 && (RW0 == AW'(i))) || (WE1 && (RW1 == AW'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Combinational read ports; a selector that matches no stored register (x0 or out of range) yields 0.
  always_comb begin
    DA       = '0;
    RBUSY    = '0;
    w_sel    = '0;
    w_stored = '0;
    w_busy   = 1'b0;
    w_hit    = 1'b0;
    w_fwd0   = 1'b0;
    w_fwd1   = 1'b0;
    for (int k = 0; k < NR; k++) begin
      w_sel    = RA[k*AW +: AW];
      w_stored = '0;
      w_busy   = 1'b0;
      w_hit    = 1'b0;
      for (int i = 1; i < N; i++) begin
        if (w_sel == AW'(i)) begin
          w_stored = r_mem[i];
          w_busy   = r_busy[i];
          w_hit    = 1'b1;
        end
      end
      // Forwarding is held off during reset so DA reads 0 while the bank is cleared.
      w_fwd1 = (BYPASS != 0) && !RST && w_hit && WE1 && (RW1 == w_sel);
      w_fwd0 = (BYPASS != 0) && !RST && w_hit && WE0 && (RW0 == w_sel);
      if (w_fwd1) begin
        DA[k*SIZE +: SIZE] = DIN1;
      end else if (w_fwd0) begin
        DA[k*SIZE +: SIZE] = DIN0;
      end else begin
        DA[k*SIZE +: SIZE] = w_stored;
      end
      RBUSY[k] = w_busy && !(w_fwd0 || w_fwd1);
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (bypass, no-bypass and 4-port instances)
module tb_regfile_mp;

  typedef struct {
    string       name;
    int          inst;
    int          port;
    logic [63:0] d;
    logic        b;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WE0 = 1'b0, WE1 = 1'b0, ISSUE = 1'b0;
  logic [4:0]  RW0 = '0, RW1 = '0, RI = '0;
  logic [63:0] DIN0 = '0, DIN1 = '0;
  logic [9:0]  RA_a = '0, RA_b = '0;
  logic [19:0] RA_c = '0;
  logic [127:0] DA_a, DA_b;
  logic [255:0] DA_c;
  logic [1:0]  RB_a, RB_b;
  logic [3:0]  RB_c;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  regfile_mp #(.N(32), .SIZE(64), .NR(2), .BYPASS(1)) dut (
    .CLK(CLK), .RST(RST), .RA(RA_a), .DA(DA_a), .RBUSY(RB_a),
    .WE0(WE0), .RW0(RW0), .DIN0(DIN0), .WE1(WE1), .RW1(RW1), .DIN1(DIN1),
    .ISSUE(ISSUE), .RI(RI));

  regfile_mp #(.N(32), .SIZE(64), .NR(2), .BYPASS(0)) dut_nb (
    .CLK(CLK), .RST(RST), .RA(RA_b), .DA(DA_b), .RBUSY(RB_b),
    .WE0(WE0), .RW0(RW0), .DIN0(DIN0), .WE1(WE1), .RW1(RW1), .DIN1(DIN1),
    .ISSUE(ISSUE), .RI(RI));

  regfile_mp #(.N(32), .SIZE(64), .NR(4), .BYPASS(1)) dut4 (
    .CLK(CLK), .RST(RST), .RA(RA_c), .DA(DA_c), .RBUSY(RB_c),
    .WE0(WE0), .RW0(RW0), .DIN0(DIN0), .WE1(WE1), .RW1(RW1), .DIN1(DIN1),
    .ISSUE(ISSUE), .RI(RI));

  // Monitor: outputs are stable mid-cycle; pop every pending expectation and compare.
  always @(negedge CLK) begin
    exp_t        e;
    logic [63:0] ad;
    logic        ab;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.inst)
        0:       begin ad = DA_a[e.port*64 +: 64]; ab = RB_a[e.port]; end
        1:       begin ad = DA_b[e.port*64 +: 64]; ab = RB_b[e.port]; end
        default: begin ad = DA_c[e.port*64 +: 64]; ab = RB_c[e.port]; end
      endcase
      vectors++;
      if (ad !== e.d || ab !== e.b) begin
        miscompares++;
        $display("FAIL %s inst%0d port%0d: DA=%h RBUSY=%b, expected DA=%h RBUSY=%b",
                 e.name, e.inst, e.port, ad, ab, e.d, e.b);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
    WE0 = 1'b0; WE1 = 1'b0; ISSUE = 1'b0;
  endtask

  task automatic ra(input int inst, input int port, input logic [4:0] v);
    case (inst)
      0:       RA_a[port*5 +: 5] = v;
      1:       RA_b[port*5 +: 5] = v;
      default: RA_c[port*5 +: 5] = v;
    endcase
  endtask

  task automatic expect_rd(input string nm, input int inst, input int port,
                           input logic [4:0] sel, input logic [63:0] d, input logic b);
    exp_t e;
    ra(inst, port, sel);
    e.name = nm; e.inst = inst; e.port = port; e.d = d; e.b = b;
    q.push_back(e);
  endtask

  task automatic wr0(input logic [4:0] r, input logic [63:0] d);
    WE0 = 1'b1; RW0 = r; DIN0 = d;
  endtask

  task automatic wr1(input logic [4:0] r, input logic [63:0] d);
    WE1 = 1'b1; RW1 = r; DIN1 = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held across edges
    cyc(); cyc();
    expect_rd("rst_hold", 0, 0, 5'd5, 64'h0, 1'b0);
    expect_rd("rst_hold", 1, 0, 5'd5, 64'h0, 1'b0);
    cyc();
    RST = 1'b0;

    // Write x5, then issue x5, then async reset with a write on the reset edge
    cyc();
    wr0(5'd5, 64'hDEAD);
    expect_rd("x5_byp", 0, 0, 5'd5, 64'hDEAD, 1'b0);
    expect_rd("x5_nobyp", 1, 0, 5'd5, 64'h0, 1'b0);
    cyc();
    ISSUE = 1'b1; RI = 5'd5;
    expect_rd("x5_stored", 0, 0, 5'd5, 64'hDEAD, 1'b0);
    expect_rd("x5_stored", 1, 0, 5'd5, 64'hDEAD, 1'b0);
    cyc();
    RST = 1'b1;
    wr0(5'd5, 64'hBEEF);
    expect_rd("rst_async", 0, 0, 5'd5, 64'h0, 1'b0);
    expect_rd("rst_async", 1, 0, 5'd5, 64'h0, 1'b0);
    cyc();
    RST = 1'b0;
    expect_rd("rst_wr_lost", 0, 0, 5'd5, 64'h0, 1'b0);
    expect_rd("rst_wr_lost", 1, 0, 5'd5, 64'h0, 1'b0);

    // x0 is hardwired
    cyc();
    wr0(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    ISSUE = 1'b1; RI = 5'd0;
    expect_rd("x0_comb", 0, 0, 5'd0, 64'h0, 1'b0);
    expect_rd("x0_comb", 1, 0, 5'd0, 64'h0, 1'b0);
    cyc();
    expect_rd("x0_after", 0, 0, 5'd0, 64'h0, 1'b0);
    expect_rd("x0_after", 1, 0, 5'd0, 64'h0, 1'b0);

    // Dual write: same register, then different registers
    cyc();
    wr0(5'd7, 64'h11); wr1(5'd7, 64'h22);
    expect_rd("same_byp", 0, 0, 5'd7, 64'h22, 1'b0);
    expect_rd("same_nobyp", 1, 0, 5'd7, 64'h0, 1'b0);
    cyc();
    wr0(5'd3, 64'hAA); wr1(5'd4, 64'hBB);
    expect_rd("same_stored", 0, 0, 5'd7, 64'h22, 1'b0);
    expect_rd("diff_byp1", 0, 1, 5'd4, 64'hBB, 1'b0);
    expect_rd("same_stored", 1, 0, 5'd7, 64'h22, 1'b0);
    expect_rd("diff_nobyp", 1, 1, 5'd3, 64'h0, 1'b0);
    cyc();
    expect_rd("diff_x3", 0, 0, 5'd3, 64'hAA, 1'b0);
    expect_rd("diff_x4", 0, 1, 5'd4, 64'hBB, 1'b0);
    expect_rd("diff_x3", 1, 0, 5'd3, 64'hAA, 1'b0);
    expect_rd("diff_x4", 1, 1, 5'd4, 64'hBB, 1'b0);

    // Bypass versus stored read of x9
    cyc();
    wr0(5'd9, 64'h55);
    cyc();
    wr0(5'd9, 64'h1234);
    expect_rd("byp_x9", 0, 0, 5'd9, 64'h1234, 1'b0);
    expect_rd("nobyp_x9_old", 1, 0, 5'd9, 64'h55, 1'b0);
    cyc();
    expect_rd("byp_x9_after", 0, 0, 5'd9, 64'h1234, 1'b0);
    expect_rd("nobyp_x9_new", 1, 0, 5'd9, 64'h1234, 1'b0);

    // Scoreboard on x12
    cyc();
    ISSUE = 1'b1; RI = 5'd12;
    expect_rd("sb_issue_cyc", 0, 0, 5'd12, 64'h0, 1'b0);
    expect_rd("sb_issue_cyc", 1, 0, 5'd12, 64'h0, 1'b0);
    cyc();
    expect_rd("sb_busy", 0, 0, 5'd12, 64'h0, 1'b1);
    expect_rd("sb_busy", 1, 0, 5'd12, 64'h0, 1'b1);
    cyc();
    wr1(5'd12, 64'h77);
    expect_rd("sb_wr_byp", 0, 0, 5'd12, 64'h77, 1'b0);
    expect_rd("sb_wr_nobyp", 1, 0, 5'd12, 64'h0, 1'b1);
    cyc();
    expect_rd("sb_cleared", 0, 0, 5'd12, 64'h77, 1'b0);
    expect_rd("sb_cleared", 1, 0, 5'd12, 64'h77, 1'b0);
    cyc();
    ISSUE = 1'b1; RI = 5'd12;
    cyc();
    ISSUE = 1'b1; RI = 5'd12;
    wr0(5'd12, 64'h99);
    expect_rd("sb_set_clr_byp", 0, 0, 5'd12, 64'h99, 1'b0);
    expect_rd("sb_set_clr_nobyp", 1, 0, 5'd12, 64'h77, 1'b1);
    cyc();
    expect_rd("sb_set_wins", 0, 0, 5'd12, 64'h99, 1'b1);
    expect_rd("sb_set_wins", 1, 0, 5'd12, 64'h99, 1'b1);

    // Four read ports: x1, x2, x1, x0 on ports 0..3
    cyc();
    wr0(5'd1, 64'h1); wr1(5'd2, 64'h2);
    expect_rd("p4_byp0", 2, 0, 5'd1, 64'h1, 1'b0);
    expect_rd("p4_byp1", 2, 1, 5'd2, 64'h2, 1'b0);
    expect_rd("p4_byp2", 2, 2, 5'd1, 64'h1, 1'b0);
    expect_rd("p4_byp3", 2, 3, 5'd0, 64'h0, 1'b0);
    cyc();
    expect_rd("p4_port0", 2, 0, 5'd1, 64'h1, 1'b0);
    expect_rd("p4_port1", 2, 1, 5'd2, 64'h2, 1'b0);
    expect_rd("p4_port2", 2, 2, 5'd1, 64'h1, 1'b0);
    expect_rd("p4_port3", 2, 3, 5'd0, 64'h0, 1'b0);
    expect_rd("p4_x12_busy", 0, 1, 5'd12, 64'h99, 1'b1);

    cyc(); cyc();
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
